// File: rtl/eth_burst_pattern_gen.sv
// eth_burst_pattern_gen
// Trigger-driven test-pattern source for the Ethernet transmit path
// (eth_gtxclk domain). A synchronised rising edge on i_trig writes one
// burst of i_len words of the selected pattern into the eth_session write
// port. The write pauses while i_full is high. One extra trigger can be
// queued while a burst runs. Any further trigger is dropped and flagged.
//
// Ports:
//   eth_gtxclk   clock
//   rst_n        asynchronous active-low reset
//   i_trig       asynchronous trigger level, rising edge starts a burst
//   i_enable     1 = new bursts may start
//   i_mode       pattern: 0 INC, 1 CONST, 2 LFSR, 3 WALK
//   i_len        burst length in words, latched at burst start
//   i_seed       first word / pattern seed, latched at burst start
//   i_full       downstream cannot accept a write this cycle
//   o_wr         registered write strobe
//   o_data       registered write data, valid while o_wr=1
//   o_busy       burst in progress (RUN or DONE)
//   o_done       one-cycle pulse with the last word of a burst
//   o_overrun    one-cycle pulse when a trigger is dropped
//   o_burst_cnt  completed bursts, wraps
module eth_burst_pattern_gen #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 13,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              eth_gtxclk,
   input  logic              rst_n,
   input  logic              i_trig,
   input  logic              i_enable,
   input  logic [1:0]        i_mode,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [DATA_W-1:0] i_seed,
   input  logic              i_full,
   output logic              o_wr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overrun,
   output logic [CNT_W-1:0]  o_burst_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
   typedef enum logic [1:0] {PAT_INC, PAT_CONST, PAT_LFSR, PAT_WALK} pat_t;

   state_t            r_state;
   pat_t              r_mode;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_cur;
   logic              r_pending;
   logic              r_s1, r_s2, r_s3;

   logic              w_edge;
   logic              w_start;
   logic              w_last;
   logic [DATA_W-1:0] w_next;
   logic [DATA_W-1:0] w_first;

   // The synchroniser flops reset high. A trigger that is already high at
   // reset release is therefore not taken as an edge.
   assign w_edge  = r_s2 & ~r_s3;
   assign w_start = (w_edge | r_pending) & i_enable & (i_len != '0);
   assign w_last  = (r_cnt == (r_len - LEN_W'(1)));
   assign o_busy  = (r_state != ST_IDLE);

   // A walking pattern needs a set bit. A zero seed in WALK mode starts at 1.
   assign w_first = ((pat_t'(i_mode) == PAT_WALK) && (i_seed == '0)) ? DATA_W'(1) : i_seed;

   always_comb begin
      w_next = r_cur;
      case (r_mode)
         PAT_INC:   w_next = r_cur + DATA_W'(1);
         PAT_CONST: w_next = r_cur;
         PAT_LFSR:  w_next = {r_cur[DATA_W-2:0], ~(r_cur[DATA_W-1] ^ r_cur[DATA_W-2])};
         PAT_WALK:  w_next = {r_cur[DATA_W-2:0], r_cur[DATA_W-1]};
         default:   w_next = r_cur;
      endcase
   end

   always_ff @(posedge eth_gtxclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mode      <= PAT_INC;
         r_len       <= '0;
         r_cnt       <= '0;
         r_cur       <= '0;
         r_pending   <= 1'b0;
         r_s1        <= 1'b1;
         r_s2        <= 1'b1;
         r_s3        <= 1'b1;
         o_wr        <= 1'b0;
         o_data      <= '0;
         o_done      <= 1'b0;
         o_overrun   <= 1'b0;
         o_burst_cnt <= '0;
      end else begin
         r_s1      <= i_trig;
         r_s2      <= r_s1;
         r_s3      <= r_s2;
         o_done    <= 1'b0;
         o_overrun <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               o_wr <= 1'b0;
               if (w_start) begin
                  r_len     <= i_len;
                  r_mode    <= pat_t'(i_mode);
                  r_cur     <= w_first;
                  r_cnt     <= '0;
                  r_pending <= 1'b0;
                  r_state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!i_full) begin
                  o_wr   <= 1'b1;
                  o_data <= r_cur;
                  r_cur  <= w_next;
                  r_cnt  <= r_cnt + LEN_W'(1);
                  if (w_last) begin
                     o_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end else begin
                  o_wr <= 1'b0;
               end
            end
            ST_DONE: begin
               o_wr        <= 1'b0;
               o_burst_cnt <= o_burst_cnt + CNT_W'(1);
               r_state     <= ST_IDLE;
            end
            default: begin
               o_wr    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase

         // An edge that arrives during a burst is queued once. A second
         // queued edge is dropped and flagged. An edge in IDLE is either
         // consumed above or ignored.
         if (w_edge && (r_state != ST_IDLE)) begin
            if (r_pending)
               o_overrun <= 1'b1;
            else
               r_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_eth_burst_pattern_gen.sv
module tb_eth_burst_pattern_gen;

   localparam int DW = 8;
   localparam int LW = 13;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          trig;
   logic          en;
   logic [1:0]    mode;
   logic [LW-1:0] len;
   logic [DW-1:0] seed;
   logic          full;
   logic          o_wr;
   logic [DW-1:0] o_data;
   logic          o_busy;
   logic          o_done;
   logic          o_overrun;
   logic [CW-1:0] o_burst_cnt;

   eth_burst_pattern_gen #(
      .DATA_W (DW),
      .LEN_W  (LW),
      .CNT_W  (CW)
   ) dut (
      .eth_gtxclk  (clk),
      .rst_n       (rst_n),
      .i_trig      (trig),
      .i_enable    (en),
      .i_mode      (mode),
      .i_len       (len),
      .i_seed      (seed),
      .i_full      (full),
      .o_wr        (o_wr),
      .o_data      (o_data),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_overrun   (o_overrun),
      .o_burst_cnt (o_burst_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Capture of the write port, sampled on the falling edge.
   logic [7:0] wr_data[$];
   int         wr_cyc[$];
   int         done_at[$];
   int         ovr_cyc[$];

   always @(negedge clk) begin
      if (o_wr) begin
         wr_data.push_back(o_data);
         wr_cyc.push_back(cyc);
      end
      if (o_done) done_at.push_back(wr_data.size());
      if (o_overrun) ovr_cyc.push_back(cyc);
   end

   int errors = 0;
   int checks = 0;

   logic [7:0] e_inc[4]  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
   logic [7:0] e_walk[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] e_lfsr[3] = '{8'hC0, 8'h81, 8'h02};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wr_at(input int idx);
      if (idx < wr_data.size()) return {24'd0, wr_data[idx]};
      return 'x;
   endfunction

   function automatic logic [31:0] cyc_at(input int idx);
      if (idx < wr_cyc.size()) return wr_cyc[idx];
      return 'x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic tick_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic run_pat(input logic [1:0] m, input logic [7:0] s, input int l, output int b);
      b    = wr_data.size();
      mode = m;
      seed = s;
      len  = LW'(l);
      trig = 1'b1;
      tick_n(4);
      trig = 1'b0;
      tick_n(l + 10);
   endtask

   initial begin
      int b, d, n0, bw;

      rst_n = 1'b0; trig = 1'b0; en = 1'b1; full = 1'b0;
      mode = 2'd0; len = LW'(10); seed = 8'h01;
      tick_n(3);
      chk("rst_wr",      o_wr, 0);
      chk("rst_data",    o_data, 0);
      chk("rst_busy",    o_busy, 0);
      chk("rst_done",    o_done, 0);
      chk("rst_overrun", o_overrun, 0);
      chk("rst_cnt",     o_burst_cnt, 0);
      rst_n = 1'b1;
      tick_n(5);

      // Basic INC burst, seed 1, len 10.
      b = wr_data.size(); d = done_at.size();
      n0 = cyc + 1;
      trig = 1'b1;
      tick_until(n0 + 4);
      chk("t1_busy", o_busy, 1);
      trig = 1'b0;
      tick_until(n0 + 20);
      chk("t1_count", wr_data.size() - b, 10);
      chk("t1_first_cyc", cyc_at(b), n0 + 3);
      chk("t1_last_cyc", cyc_at(b + 9), n0 + 12);
      for (int i = 0; i < 10; i++) chk($sformatf("t1_d%0d", i), wr_at(b + i), i + 1);
      chk("t1_done_n", done_at.size() - d, 1);
      chk("t1_done_at", (done_at.size() > d) ? done_at[d] : -1, b + 10);
      chk("t1_burst_cnt", o_burst_cnt, 1);
      chk("t1_idle", o_busy, 0);

      // Same burst with i_full high over the 3rd and 4th words.
      b = wr_data.size(); d = done_at.size();
      n0 = cyc + 1;
      trig = 1'b1;
      tick_until(n0 + 4);
      full = 1'b1;
      tick_until(n0 + 6);
      full = 1'b0;
      trig = 1'b0;
      tick_until(n0 + 22);
      chk("t2_count", wr_data.size() - b, 10);
      chk("t2_cyc1", cyc_at(b + 1), n0 + 4);
      chk("t2_cyc2", cyc_at(b + 2), n0 + 7);
      chk("t2_cyc9", cyc_at(b + 9), n0 + 14);
      for (int i = 0; i < 10; i++) chk($sformatf("t2_d%0d", i), wr_at(b + i), i + 1);
      chk("t2_done_n", done_at.size() - d, 1);
      chk("t2_burst_cnt", o_burst_cnt, 2);

      // len 20 with a queued second trigger and a dropped third trigger.
      len = LW'(20);
      b = wr_data.size(); d = done_at.size(); bw = ovr_cyc.size();
      n0 = cyc + 1;
      trig = 1'b1;
      tick_until(n0 + 2);  trig = 1'b0;
      tick_until(n0 + 5);  trig = 1'b1;
      tick_until(n0 + 8);  trig = 1'b0;
      tick_until(n0 + 11); trig = 1'b1;
      tick_until(n0 + 14); trig = 1'b0;
      tick_until(n0 + 60);
      chk("t3_count", wr_data.size() - b, 40);
      chk("t3_b1_first", cyc_at(b), n0 + 3);
      chk("t3_b1_last", cyc_at(b + 19), n0 + 22);
      chk("t3_b2_first", cyc_at(b + 20), n0 + 25);
      chk("t3_b2_last", cyc_at(b + 39), n0 + 44);
      for (int i = 0; i < 40; i++) chk($sformatf("t3_d%0d", i), wr_at(b + i), (i % 20) + 1);
      chk("t3_ovr_n", ovr_cyc.size() - bw, 1);
      chk("t3_ovr_cyc", (ovr_cyc.size() > bw) ? ovr_cyc[bw] : -1, n0 + 14);
      chk("t3_done_n", done_at.size() - d, 2);
      chk("t3_burst_cnt", o_burst_cnt, 4);
      chk("t3_idle", o_busy, 0);

      // Pattern modes.
      run_pat(2'd0, 8'hFE, 4, b);
      chk("inc_count", wr_data.size() - b, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("inc_d%0d", i), wr_at(b + i), e_inc[i]);
      run_pat(2'd3, 8'h00, 9, b);
      chk("walk_count", wr_data.size() - b, 9);
      for (int i = 0; i < 9; i++) chk($sformatf("walk_d%0d", i), wr_at(b + i), e_walk[i]);
      run_pat(2'd1, 8'h5A, 3, b);
      chk("const_count", wr_data.size() - b, 3);
      for (int i = 0; i < 3; i++) chk($sformatf("const_d%0d", i), wr_at(b + i), 8'h5A);
      run_pat(2'd2, 8'hC0, 3, b);
      chk("lfsr_count", wr_data.size() - b, 3);
      for (int i = 0; i < 3; i++) chk($sformatf("lfsr_d%0d", i), wr_at(b + i), e_lfsr[i]);
      chk("pat_burst_cnt", o_burst_cnt, 8);

      // Edge in IDLE with i_enable=0 is ignored and not queued.
      mode = 2'd0; seed = 8'h10; len = LW'(5);
      b = wr_data.size();
      en = 1'b0; trig = 1'b1;
      tick_n(4);
      trig = 1'b0;
      tick_n(6);
      en = 1'b1;
      tick_n(8);
      chk("en0_ignored", wr_data.size() - b, 0);

      // i_enable low mid-burst: burst completes, queued trigger waits.
      b = wr_data.size();
      n0 = cyc + 1;
      trig = 1'b1;
      tick_until(n0 + 1); trig = 1'b0;
      tick_until(n0 + 2); trig = 1'b1;
      tick_until(n0 + 3); en = 1'b0;
      tick_until(n0 + 4); trig = 1'b0;
      tick_until(n0 + 25);
      chk("en_hold_count", wr_data.size() - b, 5);
      chk("en_hold_idle", o_busy, 0);
      en = 1'b1;
      tick_n(12);
      chk("en_resume_count", wr_data.size() - b, 10);
      for (int i = 0; i < 10; i++) chk($sformatf("en_d%0d", i), wr_at(b + i), 8'h10 + (i % 5));
      chk("en_burst_cnt", o_burst_cnt, 10);

      // Trigger held high through reset release.
      trig = 1'b1; rst_n = 1'b0;
      tick_n(2);
      chk("rst2_cnt", o_burst_cnt, 0);
      b = wr_data.size();
      rst_n = 1'b1;
      tick_n(10);
      chk("trig_high_no_burst", wr_data.size() - b, 0);
      chk("trig_high_idle", o_busy, 0);
      trig = 1'b0;
      tick_n(5);

      // Zero length: ignored, not queued.
      b = wr_data.size(); d = done_at.size();
      len = LW'(0);
      trig = 1'b1;
      tick_n(4);
      trig = 1'b0;
      tick_n(10);
      chk("len0_no_wr", wr_data.size() - b, 0);
      chk("len0_no_done", done_at.size() - d, 0);
      len = LW'(3);
      tick_n(8);
      chk("len0_not_queued", wr_data.size() - b, 0);

      // Reset asserted mid-burst.
      mode = 2'd0; seed = 8'h01; len = LW'(20);
      n0 = cyc + 1;
      trig = 1'b1;
      tick_until(n0 + 8);
      chk("mid_wr_active", o_wr, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr",   o_wr, 0);
      chk("mid_rst_data", o_data, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_done", o_done, 0);
      chk("mid_rst_cnt",  o_burst_cnt, 0);
      trig = 1'b0;
      tick_n(2);
      bw = wr_data.size();
      rst_n = 1'b1;
      tick_n(10);
      chk("post_rst_no_wr", wr_data.size() - bw, 0);
      chk("post_rst_cnt", o_burst_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_burst_pattern_gen.md
Name: eth_burst_pattern_gen

Overview:
- Trigger-driven, parametrised test-pattern source for the Ethernet transmit path; runs in the eth_gtxclk domain and feeds the write side of eth_session (i_data/i_wr/o_full).
- On a synchronised rising edge of i_trig, writes one burst of a run-time-programmable length.
- Selectable data pattern, back-pressure stall, single-deep trigger queueing, overrun flag and burst counter.
- Used for bench bring-up and for on-board link self-test.

Parameters:
DATA_W, 8, width of generated data words
LEN_W, 13, width of burst-length input and internal word counter
CNT_W, 16, width of completed-burst counter

Ports:
eth_gtxclk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_trig  in  1  asynchronous trigger level; rising edge starts a burst
i_enable  in  1  1 = new bursts may start
i_mode  in  2  pattern: 0 INC, 1 CONST, 2 LFSR, 3 WALK
i_len  in  LEN_W  burst length in words; latched at burst start
i_seed  in  DATA_W  first word / pattern seed; latched at burst start
i_full  in  1  downstream cannot accept a write this cycle
o_wr  out  1  write strobe, registered
o_data  out  DATA_W  write data, valid while o_wr=1, registered
o_busy  out  1  state is RUN or DONE
o_done  out  1  one-cycle pulse when the last word of a burst is written
o_overrun  out  1  one-cycle pulse when a trigger is dropped
o_burst_cnt  out  CNT_W  completed bursts, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0, async):
  - o_wr=0, o_data=0, o_busy=0, o_done=0, o_overrun=0, o_burst_cnt=0.
  - State IDLE, pending=0.
  - Synchroniser flops s1, s2, s3 reset to 1, so i_trig already high at reset release gives no edge.
- Trigger path:
  - s1<=i_trig, s2<=s1, s3<=s2.
  - Edge flag = s2 & ~s3, combinational.
- States:
  - IDLE -> RUN when (edge flag or pending) & i_enable & i_len!=0.
    - Latch len, mode and seed; cur<=seed (WALK with seed 0: cur<=1); word counter<=0; clear pending if consumed.
  - Edge in IDLE with i_enable=0 or i_len=0: ignored; no flag, no pending.
  - RUN:
    - Each cycle with i_full=0: o_wr<=1, o_data<=cur, cur<=next(cur), cnt<=cnt+1.
    - Cycle with i_full=1: o_wr<=0, all state held.
    - Word issued with cnt==len-1: o_done<=1, -> DONE.
  - DONE (1 cycle): o_wr=0; o_burst_cnt increments; -> IDLE.
- Latency: if i_trig is first sampled high at edge N, IDLE->RUN at edge N+2 and o_wr first high after edge N+3 (i_full=0).
- Queueing: edge flag while in RUN or DONE:
  - pending=0: set pending=1.
  - pending=1: o_overrun pulses, trigger dropped.
  - A pending burst starts from IDLE with no gap beyond the one-cycle IDLE pass. Inputs are latched at that start, not at the queued edge.
- i_enable going low mid-burst: current burst completes; a pending trigger is held until i_enable=1.
- Pattern next(cur), all arithmetic modulo 2^DATA_W:
  - INC: cur+1, wraps 2^DATA_W-1 -> 0.
  - CONST: cur.
  - LFSR: {cur[DATA_W-2:0], ~(cur[DATA_W-1]^cur[DATA_W-2])}; not required maximal-length.
  - WALK: rotate-left by 1.
- Burst length: i_len=2^LEN_W-1 is the maximum. The counter compare uses the latched length, so changes to i_len mid-burst have no effect.
- Simultaneous events: in the cycle the last word is written, an edge flag sets pending (or overruns) exactly as in RUN.

Test Plan:
- Reset, i_trig 0->1, mode INC, seed 1, len 10, i_full=0 -> o_wr high for exactly 10 consecutive cycles starting edge N+3, data 1..10, o_done pulse with the 10th word, o_burst_cnt=1.
- Same burst with i_full held high on the 3rd and 4th words -> o_wr gaps of 2 cycles, data 1..10 unbroken and in order, still exactly 10 writes.
- Two further trigger edges during a len-20 burst -> second burst of 20 starts right after DONE, third edge raises o_overrun for 1 cycle, o_burst_cnt=2.
- Mode INC, seed 0xFE, len 4 -> FE, FF, 00, 01. Mode WALK, seed 0, len 9 -> 01, 02, 04, …, 80, 01. Mode CONST, seed 0x5A, len 3 -> 5A ×3.
- i_trig held high through reset release -> no burst. i_len=0 trigger -> no o_wr, no o_done. rst_n asserted mid-burst -> o_wr=0 immediately and all outputs/counters return to reset values.
